mult_div_unit: RTL

- Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
- Sits directly downstream of the register bank and consumes its two read-data outputs (rs→opA, rt→opB).
- Executes MULT, MULTU, DIV, DIVU as a multi-cycle operation with a start/busy/done handshake.
- Supports MTHI/MTLO single-cycle writes; HI/LO feed MFHI/MFLO back toward the register-bank write-data path.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/muldiv_datapath.sv | 80 ++++++++
 rtl/mult_div_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit:
// op codes, FSM state encoding and default widths.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } opE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } stateE;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the register bank side (master) and
// the multiply/divide unit (slave), including the architectural HI/LO.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic             divByZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opA, opB,
        input  busy, done, divByZero, hi, lo
    );

    modport slave (
        input  start, op, opA, opB,
        output busy, done, divByZero, hi, lo
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring shift-subtract divide accumulator with its
// iteration counter. Build option MULDIV_FAST_MULT_EN loads the full product in one cycle.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               loadMul,
    input  logic               loadDiv,
    input  logic               step,
    input  logic [WIDTH-1:0]   magA,
    input  logic [WIDTH-1:0]   magB,
    output logic               lastIter,
    output logic [2*WIDTH-1:0] result
);

    // acc holds {product upper, multiplier bits} or {remainder, quotient/dividend bits}
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic [CNT_W-1:0]   count;
    logic               isDiv;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShifted;
    logic [WIDTH:0]     divDiff;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mulSum     = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            mulSum = mulSum + {1'b0, operand};
        end
        divShifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divDiff    = divShifted - {1'b0, operand};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            operand <= '0;
            count   <= '0;
            isDiv   <= 1'b0;
        end else if (loadMul) begin
            operand <= magA;
            isDiv   <= 1'b0;
`ifdef MULDIV_FAST_MULT_EN
            acc     <= {{WIDTH{1'b0}}, magA} * {{WIDTH{1'b0}}, magB};
            count   <= '0;
`else
            acc     <= {{WIDTH{1'b0}}, magB};
            count   <= CNT_W'(WIDTH);
`endif
        end else if (loadDiv) begin
            acc     <= {{WIDTH{1'b0}}, magA};
            operand <= magB;
            count   <= CNT_W'(WIDTH);
            isDiv   <= 1'b1;
        end else if (step) begin
            count <= count - 1'b1;
            if (isDiv) begin
                // Restoring step: keep the trial difference only when it did not borrow
                if (divDiff[WIDTH]) begin
                    acc <= {divShifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                end else begin
                    acc <= {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                end
            end else begin
                acc <= {mulSum, acc[WIDTH-1:1]};
            end
        end
    end

    assign lastIter = (count == CNT_W'(1));
    assign result   = acc;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS multiply/divide unit holding HI/LO; FSM controls muldiv_datapath.
// Build option MULDIV_FAST_MULT_EN gives single-cycle MULT/MULTU with identical results.
module mult_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic            clk,
    input logic            rst,
    mult_div_unit_if.slave bus
);

    stateE              state, stateNext;
    logic               loadMul, loadDiv, step, lastIter;
    logic               signedOp, isMulReq, isDivReq;
    logic [WIDTH-1:0]   magA, magB;
    logic [2*WIDTH-1:0] rawResult, finalResult;

    logic               isMulOp, negHi, negLo, dbzPending;
    logic [WIDTH-1:0]   hiReg, loReg;
    logic               doneReg, dbzReg;

    always_comb begin
        isMulReq = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        isDivReq = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        signedOp = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        magA     = (signedOp && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
        magB     = (signedOp && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;
    end

    muldiv_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .loadMul  (loadMul),
        .loadDiv  (loadDiv),
        .step     (step),
        .magA     (magA),
        .magB     (magB),
        .lastIter (lastIter),
        .result   (rawResult)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        loadMul   = 1'b0;
        loadDiv   = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && isMulReq) begin
                    loadMul = 1'b1;
`ifdef MULDIV_FAST_MULT_EN
                    stateNext = FINISH;
`else
                    stateNext = MUL;
`endif
                end else if (bus.start && isDivReq) begin
                    // A zero divisor skips the iterations and reports through FINISH
                    if (bus.opB == '0) begin
                        stateNext = FINISH;
                    end else begin
                        loadDiv   = 1'b1;
                        stateNext = DIV;
                    end
                end
            end
            MUL, DIV: begin
                step = 1'b1;
                if (lastIter) begin
                    stateNext = FINISH;
                end
            end
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Products negate as one 2*WIDTH value; quotient and remainder negate independently
    always_comb begin
        finalResult = rawResult;
        if (isMulOp) begin
            if (negLo) begin
                finalResult = -rawResult;
            end
        end else begin
            if (negHi) begin
                finalResult[2*WIDTH-1:WIDTH] = -rawResult[2*WIDTH-1:WIDTH];
            end
            if (negLo) begin
                finalResult[WIDTH-1:0] = -rawResult[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            isMulOp    <= 1'b0;
            negHi      <= 1'b0;
            negLo      <= 1'b0;
            dbzPending <= 1'b0;
            hiReg      <= '0;
            loReg      <= '0;
            doneReg    <= 1'b0;
            dbzReg     <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                if (isMulReq) begin
                    isMulOp    <= 1'b1;
                    negHi      <= signedOp & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
                    negLo      <= signedOp & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
                    dbzPending <= 1'b0;
                end else if (isDivReq) begin
                    isMulOp    <= 1'b0;
                    negHi      <= signedOp & bus.opA[WIDTH-1];
                    negLo      <= signedOp & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
                    dbzPending <= (bus.opB == '0);
                end else if (bus.op == OP_MTHI) begin
                    hiReg <= bus.opA;
                end else if (bus.op == OP_MTLO) begin
                    loReg <= bus.opA;
                end
            end
            if (state == FINISH && !dbzPending) begin
                {hiReg, loReg} <= finalResult;
            end
            doneReg <= (state == FINISH);
            dbzReg  <= (state == FINISH) && dbzPending;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = doneReg;
    assign bus.divByZero = dbzReg;
    assign bus.hi        = hiReg;
    assign bus.lo        = loReg;

endmodule
